// File: rtl/keccak_lane_loader.sv
// Absorb-side lane demultiplexer: collects LANE_W-bit lanes into a rate block
// and presents the complete (or final partial) block with a valid/ready handshake.
module keccak_lane_loader #(
    parameter int LANE_W     = 64,
    parameter int RATE_LANES = 17,
    parameter int IDX_W      = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANE_W-1:0]            in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [RATE_LANES*LANE_W-1:0] blk_data,
    output logic                         blk_valid,
    output logic                         blk_last,
    output logic [IDX_W:0]               blk_lanes,
    input  logic                         blk_ready
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            blk_data  <= '0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            blk_lanes <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        blk_data[LANE_W*int'(idx) +: LANE_W] <= in_data;
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX || in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_last  <= in_last;
                            blk_lanes <= {1'b0, idx} + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Clearing on handoff keeps unwritten lanes of the next block zero.
                    if (blk_ready) begin
                        state     <= FILL;
                        idx       <= '0;
                        blk_data  <= '0;
                        in_ready  <= 1'b1;
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        blk_lanes <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
